config_loader: RTL

// - Upstream driver of the logic-cell configuration shift chain: accepts a byte-wide bitstream over valid/ready,

---
 rtl/config_loader_if.sv | 22 ++
 rtl/config_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/config_loader_if.sv
// Host-side byte stream into the configuration loader: start pulse plus valid/ready data.
interface config_loader_if;
    logic       i_Start;
    logic [7:0] i_Data;
    logic       i_Valid;
    logic       o_Ready;

    // Host drives start and data; the loader answers with ready.
    modport master (
        output i_Start,
        output i_Data,
        output i_Valid,
        input  o_Ready
    );

    modport slave (
        input  i_Start,
        input  i_Data,
        input  i_Valid,
        output o_Ready
    );
endinterface

// File: rtl/config_loader.sv
// Configuration chain loader: takes a byte stream, serialises CHAIN_LENGTH bits onto the
// shift chain with a divided, registered shift clock, then checks a trailing CRC-16-CCITT
// and releases the fabric only when the CRC matches.
module config_loader #(
    parameter int unsigned CHAIN_LENGTH = 80,
    parameter int unsigned CLK_DIV      = 1
) (
    input  logic           i_Clock,
    input  logic           i_Reset_n,
    config_loader_if.slave host,
    output logic           o_ConfigClock,
    output logic           o_ConfigShiftInput,
    input  logic           i_ConfigShiftOutput,
    output logic           o_ConfigActive,
    output logic           o_Done,
    output logic           o_Error
);

    localparam int unsigned BitW = $clog2(CHAIN_LENGTH + 1);
    localparam int unsigned DivW = $clog2(CLK_DIV + 1);

    localparam logic [BitW-1:0] ChainLast = BitW'(CHAIN_LENGTH - 1);
    localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [15:0]     CrcInit   = 16'hFFFF;
    localparam logic [15:0]     CrcPoly   = 16'h1021;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCrcLo,
        StCrcHi,
        StCheck,
        StDone,
        StError
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      byte_q, byte_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0] div_q, div_d;
    logic            cclk_q, cclk_d;
    logic            sin_q, sin_d;
    logic [15:0]     crc_q, crc_d;
    logic [15:0]     exp_q, exp_d;
    logic            active_q, active_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic [15:0]     crc_step;
    logic [2:0]      bit_idx_inc;
    logic            crc_fb;

    // Readback path is reserved; keep the input visibly consumed.
    logic unused_shift_out;
    assign unused_shift_out = i_ConfigShiftOutput;

    // One serial CRC step over the bit currently presented to the chain.
    always_comb begin
        crc_fb   = crc_q[15] ^ sin_q;
        crc_step = {crc_q[14:0], 1'b0} ^ (crc_fb ? CrcPoly : 16'h0000);
    end

    assign bit_idx_inc = bit_idx_q + 3'd1;

    // State register and all datapath registers.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= StIdle;
            byte_q    <= '0;
            bit_idx_q <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            cclk_q    <= 1'b0;
            sin_q     <= 1'b0;
            crc_q     <= '0;
            exp_q     <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            bit_idx_q <= bit_idx_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            cclk_q    <= cclk_d;
            sin_q     <= sin_d;
            crc_q     <= crc_d;
            exp_q     <= exp_d;
            active_q  <= active_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state and datapath updates; cclk_q doubles as the phase flag (0 = A, 1 = B).
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        bit_idx_d = bit_idx_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        cclk_d    = 1'b0;
        sin_d     = sin_q;
        crc_d     = crc_q;
        exp_d     = exp_q;
        active_d  = active_q;
        done_d    = done_q;
        error_d   = error_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (host.i_Start) begin
                    state_d   = StLoad;
                    bit_idx_d = '0;
                    bit_cnt_d = '0;
                    div_d     = '0;
                    crc_d     = CrcInit;
                    active_d  = 1'b0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                end
            end

            StLoad: begin
                if (host.i_Valid) begin
                    byte_d    = host.i_Data;
                    sin_d     = host.i_Data[0];
                    bit_idx_d = '0;
                    div_d     = '0;
                    state_d   = StShift;
                end
            end

            StShift: begin
                if (!cclk_q) begin
                    // Phase A: data set up, clock low.
                    if (div_q == DivLast) begin
                        div_d  = '0;
                        cclk_d = 1'b1;
                        crc_d  = crc_step;
                    end else begin
                        div_d  = div_q + DivW'(1);
                    end
                end else begin
                    // Phase B: clock high, data held.
                    if (div_q == DivLast) begin
                        div_d     = '0;
                        cclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                        bit_idx_d = bit_idx_inc;
                        if (bit_cnt_q == ChainLast) begin
                            // Any remaining pad bits of this byte are dropped here.
                            state_d = StCrcLo;
                        end else if (bit_idx_q == 3'd7) begin
                            state_d = StLoad;
                        end else begin
                            sin_d = byte_q[bit_idx_inc];
                        end
                    end else begin
                        div_d  = div_q + DivW'(1);
                        cclk_d = 1'b1;
                    end
                end
            end

            StCrcLo: begin
                if (host.i_Valid) begin
                    exp_d[7:0] = host.i_Data;
                    state_d    = StCrcHi;
                end
            end

            StCrcHi: begin
                if (host.i_Valid) begin
                    exp_d[15:8] = host.i_Data;
                    state_d     = StCheck;
                end
            end

            StCheck: begin
                if (crc_q == exp_q) begin
                    state_d  = StDone;
                    active_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    state_d  = StError;
                    error_d  = 1'b1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Ready is a pure state decode so it never depends on i_Valid.
    always_comb begin
        host.o_Ready = (state_q == StLoad) || (state_q == StCrcLo) || (state_q == StCrcHi);
    end

    assign o_ConfigClock      = cclk_q;
    assign o_ConfigShiftInput = sin_q;
    assign o_ConfigActive     = active_q;
    assign o_Done             = done_q;
    assign o_Error            = error_q;

endmodule
